// File: rtl/mem_wb_writeback_pkg.sv
// Shared definitions for the MEM/WB writeback stage: control-byte bit
// positions, halt FSM states and default datapath sizes.
package mem_wb_writeback_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    localparam int unsigned CTL_REG_WRITE  = 0;
    localparam int unsigned CTL_MEM_TO_REG = 1;
    localparam int unsigned CTL_VALID      = 2;
    localparam int unsigned CTL_HALT       = 3;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } wb_state_e;

endpackage

// File: rtl/mem_wb_writeback_if.sv
// Bundle of the MEM/WB latch outputs, decode read ports and writeback
// status consumed/produced by the writeback stage.
interface mem_wb_writeback_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic        [7:0]        control_WB;
    logic signed [DATA_W-1:0] d2_WB;
    logic signed [DATA_W-1:0] save_mem;
    logic        [ADDR_W-1:0] rd_WB;
    logic        [ADDR_W-1:0] rs1;
    logic        [ADDR_W-1:0] rs2;
    logic signed [DATA_W-1:0] rdata1;
    logic signed [DATA_W-1:0] rdata2;
    logic                     wb_en;
    logic        [ADDR_W-1:0] wb_rd;
    logic signed [DATA_W-1:0] wb_data;
    logic        [31:0]       retired;
    logic                     halted;

    modport master (
        output control_WB, d2_WB, save_mem, rd_WB, rs1, rs2,
        input  rdata1, rdata2, wb_en, wb_rd, wb_data, retired, halted
    );

    modport slave (
        input  control_WB, d2_WB, save_mem, rd_WB, rs1, rs2,
        output rdata1, rdata2, wb_en, wb_rd, wb_data, retired, halted
    );
endinterface

// File: rtl/wb_regfile.sv
// Architectural register file: one write port, two combinational read
// ports with write-through bypass; register 0 is hardwired to zero.
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     we,
    input  logic        [ADDR_W-1:0] waddr,
    input  logic signed [DATA_W-1:0] wdata,
    input  logic        [ADDR_W-1:0] raddr1,
    input  logic        [ADDR_W-1:0] raddr2,
    output logic signed [DATA_W-1:0] rdata1,
    output logic signed [DATA_W-1:0] rdata2
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic signed [DATA_W-1:0] regs [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regs <= '{default: '0};
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (raddr1 != '0) begin
            rdata1 = (we && (raddr1 == waddr)) ? wdata : regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 != '0) begin
            rdata2 = (we && (raddr2 == waddr)) ? wdata : regs[raddr2];
        end
    end

endmodule

// File: rtl/mem_wb_writeback.sv
// Writeback stage: decodes the MEM/WB control byte, selects the result,
// commits it to the register file, counts retirements and handles halt.
module mem_wb_writeback
    import mem_wb_writeback_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input logic              clock,
    input logic              reset,
    mem_wb_writeback_if.slave bus
);
    wb_state_e   state;
    wb_state_e   state_next;
    logic        reg_write;
    logic        mem_to_reg;
    logic        valid;
    logic        halt;
    logic        ctl_unused;
    logic        wb_en;
    logic [31:0] retired_q;

    assign reg_write  = bus.control_WB[CTL_REG_WRITE];
    assign mem_to_reg = bus.control_WB[CTL_MEM_TO_REG];
    assign valid      = bus.control_WB[CTL_VALID];
    assign halt       = bus.control_WB[CTL_HALT];
    assign ctl_unused = &bus.control_WB[7:4];

    // Gated by reset as well so a clock edge during reset cannot bypass or write.
    assign wb_en = valid & reg_write & (bus.rd_WB != '0) & (state == RUN) & reset;

    assign bus.wb_data = mem_to_reg ? bus.save_mem : bus.d2_WB;
    assign bus.wb_rd   = bus.rd_WB;
    assign bus.wb_en   = wb_en;
    assign bus.retired = retired_q;
    assign bus.halted  = (state == HALTED);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            RUN:     if (valid && halt) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    // Saturating count of valid instructions seen while running.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retired_q <= '0;
        end else if (valid && (state == RUN) && (retired_q != '1)) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    wb_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clock  (clock),
        .reset  (reset),
        .we     (wb_en),
        .waddr  (bus.rd_WB),
        .wdata  (bus.wb_data),
        .raddr1 (bus.rs1),
        .raddr2 (bus.rs2),
        .rdata1 (bus.rdata1),
        .rdata2 (bus.rdata2)
    );

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed and randomized checks of mem_wb_writeback against an
// instruction-level model of the register file, counter and halt flag.
module tb_mem_wb_writeback;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    logic signed [31:0] model_regs [32];
    logic [31:0]        model_retired;
    logic               model_halted;

    mem_wb_writeback_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    mem_wb_writeback #(.DATA_W(32), .ADDR_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'sd0;
        model_retired = 32'd0;
        model_halted  = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic en,
                                               input logic [4:0] rd, input logic [31:0] data);
        if (a == 5'd0) return 32'd0;
        if (en && a == rd) return data;
        return model_regs[a];
    endfunction

    // Entered at posedge+1; presents one instruction, checks, then commits it in the model.
    task automatic present(input logic [7:0] ctl, input logic [4:0] rd,
                           input logic [31:0] d2, input logic [31:0] sm,
                           input logic [4:0] a1, input logic [4:0] a2);
        logic        exp_en;
        logic [31:0] exp_data;
        bus.control_WB = ctl;
        bus.rd_WB      = rd;
        bus.d2_WB      = d2;
        bus.save_mem   = sm;
        bus.rs1        = a1;
        bus.rs2        = a2;
        exp_data = ctl[1] ? sm : d2;
        exp_en   = ctl[2] && ctl[0] && (rd != 5'd0) && !model_halted;
        #2;
        check("wb_en",   {31'd0, bus.wb_en}, {31'd0, exp_en});
        check("wb_data", bus.wb_data, exp_data);
        check("wb_rd",   {27'd0, bus.wb_rd}, {27'd0, rd});
        check("rdata1",  bus.rdata1, model_read(a1, exp_en, rd, exp_data));
        check("rdata2",  bus.rdata2, model_read(a2, exp_en, rd, exp_data));
        check("retired", bus.retired, model_retired);
        check("halted",  {31'd0, bus.halted}, {31'd0, model_halted});
        @(posedge clock);
        if (exp_en) model_regs[rd] = exp_data;
        if (ctl[2] && !model_halted) begin
            if (model_retired != 32'hFFFF_FFFF) model_retired = model_retired + 32'd1;
            if (ctl[3]) model_halted = 1'b1;
        end
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_clear();
        reset = 1'b0;
        bus.control_WB = 8'h05;
        bus.rd_WB      = 5'd3;
        bus.d2_WB      = 32'h1234;
        bus.save_mem   = 32'd0;
        bus.rs1        = 5'd3;
        bus.rs2        = 5'd0;

        // Outputs while held in reset
        repeat (2) @(posedge clock);
        #1;
        check("rst_wb_en",   {31'd0, bus.wb_en}, 32'd0);
        check("rst_rdata1",  bus.rdata1, 32'd0);
        check("rst_retired", bus.retired, 32'd0);
        check("rst_halted",  {31'd0, bus.halted}, 32'd0);
        check("rst_wb_data", bus.wb_data, 32'h1234);
        check("rst_wb_rd",   {27'd0, bus.wb_rd}, 32'd3);
        reset = 1'b1;

        // Directed plan items
        present(8'h05, 5'd3, 32'h1234, 32'd0, 5'd0, 5'd0);
        present(8'h00, 5'd0, 32'd0, 32'd0, 5'd3, 5'd3);
        check("x3_after_write", bus.rdata1, 32'h1234);
        present(8'h07, 5'd5, 32'd99, -32'sd7, 5'd5, 5'd5);
        present(8'h05, 5'd0, 32'd42, 32'd0, 5'd0, 5'd5);
        present(8'h08, 5'd9, 32'd1, 32'd2, 5'd9, 5'd0);
        present(8'hF5, 5'd9, 32'd77, 32'd3, 5'd9, 5'd9);
        present(8'h01, 5'd10, 32'd5, 32'd6, 5'd10, 5'd9);

        // Randomized traffic, halt bit masked off
        for (int n = 0; n < 300; n++) begin
            present(8'($urandom_range(0, 255)) & 8'hF7, 5'($urandom_range(0, 31)),
                    $urandom, $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // Counter saturation from a preloaded near-maximum count
        bus.control_WB = 8'h00;
        force dut.retired_q = 32'hFFFF_FFFE;
        #1;
        release dut.retired_q;
        model_retired = 32'hFFFF_FFFE;
        #1;
        present(8'h04, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        present(8'h04, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        present(8'h04, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        present(8'h00, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        check("sat_retired", bus.retired, 32'hFFFF_FFFF);

        // Reset again, then halt sequence
        reset = 1'b0;
        #1;
        reset = 1'b1;
        model_clear();
        present(8'h0D, 5'd4, 32'd8, 32'd0, 5'd4, 5'd0);
        present(8'h05, 5'd6, 32'd123, 32'd0, 5'd4, 5'd6);
        present(8'h05, 5'd6, 32'd55, 32'd0, 5'd6, 5'd4);
        check("halt_x4",      bus.rdata2, 32'd8);
        check("halt_retired", bus.retired, 32'd1);
        check("halt_flag",    {31'd0, bus.halted}, 32'd1);

        // Asynchronous reset mid-cycle; an edge during reset writes nothing
        bus.control_WB = 8'h05;
        bus.rd_WB      = 5'd7;
        bus.d2_WB      = 32'd5;
        bus.rs1        = 5'd4;
        bus.rs2        = 5'd7;
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        check("async_rdata1",  bus.rdata1, 32'd0);
        check("async_retired", bus.retired, 32'd0);
        check("async_halted",  {31'd0, bus.halted}, 32'd0);
        check("async_wb_en",   {31'd0, bus.wb_en}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        present(8'h00, 5'd0, 32'd0, 32'd0, 5'd7, 5'd4);
        check("no_write_in_reset", bus.rdata1, 32'd0);
        present(8'h05, 5'd3, 32'd11, 32'd0, 5'd3, 5'd0);
        present(8'h00, 5'd0, 32'd0, 32'd0, 5'd3, 5'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_writeback.md
# mem_wb_writeback

Writeback-stage consumer of the MEM/WB pipeline latch: decodes the latched 8-bit control byte, selects ALU result or load data, and commits it to a 32×32 architectural register file. Also provides the decode stage's two combinational read ports with same-cycle write bypass, and the EX-stage forwarding view of the pending writeback. Includes a retired-instruction counter and a halt FSM. Sits at the far end of the MEM/WB register, in the same clock domain.

## Interface
- DATA_W, 32, datapath width (signed)
- ADDR_W, 5, register address width (2**ADDR_W registers)
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- control_WB  in  8  latched control byte: [0] reg_write, [1] mem_to_reg, [2] valid, [3] halt, [7:4] reserved, ignored
- d2_WB  in  DATA_W  signed ALU result
- save_mem  in  DATA_W  signed memory read data
- rd_WB  in  ADDR_W  destination register
- rs1, rs2  in  ADDR_W  decode-stage read addresses
- rdata1, rdata2  out  DATA_W  signed read data (combinational)
- wb_en  out  1  writeback commits this cycle
- wb_rd  out  ADDR_W  destination being committed (equals rd_WB)
- wb_data  out  DATA_W  selected writeback value
- retired  out  32  count of valid instructions retired
- halted  out  1  core halted

## Operation
- wb_data = mem_to_reg ? save_mem : d2_WB; always driven regardless of valid.
- wb_en = valid & reg_write & (rd_WB != 0) & (state == RUN) & reset.
- Register write: at rising edge with wb_en=1, regs[rd_WB] <= wb_data. Register 0 never written; reads of 0 return 0.
- Read ports: rdataN = 0 if rsN==0; else wb_data if wb_en & rsN==rd_WB (write-through bypass); else regs[rsN]. Both ports may address the same register, both bypass.
- Retire counter: increments by 1 at each edge with valid=1 in RUN, independent of reg_write; saturates at 32'hFFFF_FFFF (no wrap).
- FSM, two states:
  - RUN: normal. valid & halt -> HALTED next edge; the halting instruction itself retires and performs its write if wb_en.
  - HALTED: no register writes, counter frozen, halted=1. Exits only through reset.
- Reserved control bits and halt with valid=0 have no effect.
- Reset (any time, including mid-write): all registers 0, retired=0, state RUN; asynchronous; an edge coinciding with asserted reset performs no write.

## Timing
- Register write latency 1 edge; value visible on rdata in the same cycle via bypass, from the array the cycle after.
- Counter and halted update at the edge following the qualifying input; halted rises exactly one cycle after the halt instruction is presented.
- Outputs under reset: retired=0, halted=0, wb_en=0, rdata1/rdata2=0; wb_rd and wb_data follow inputs.
- No handshake: one instruction per cycle, consumed unconditionally; upstream holds zeros (control 0) as bubbles.

## Structure
- Shared package: control-bit index constants (CTL_REG_WRITE=0, CTL_MEM_TO_REG=1, CTL_VALID=2, CTL_HALT=3), FSM state enum {RUN, HALTED}, DATA_W/ADDR_W defaults.
- One sub-module: wb_regfile (array, one write port, two bypassed read ports, x0 handling). Mux, counter, FSM in the top.

## Test plan
- Reset then control=8'h05, rd=3, d2=32'h1234 -> wb_en=1; next cycle rs1=3 gives 32'h1234, retired=1.
- Same cycle read: control=8'h07, rd=5, save_mem=-7, d2=99, rs1=rs2=5 -> rdata1=rdata2=-7 (bypass and mem_to_reg).
- Write to x0: control=8'h05, rd=0, d2=42 -> wb_en=0, rs1=0 reads 0, retired increments.
- Halt: control=8'h0D, rd=4, d2=8 -> reg4=8, halted=1 next cycle; subsequent control=8'h05 rd=6 -> no write, retired unchanged.
- Counter saturation: force retired to 32'hFFFF_FFFE, present 3 valid instructions -> holds 32'hFFFF_FFFF.
- Async reset asserted mid-cycle after writes -> rdata, retired, halted drop to 0 before next edge; edge during reset writes nothing.
